// File: rtl/gf180mcu_fd_sc_mcu9t5v0__latrf_pkg.sv
// Shared types and constants for the latch register-file write controller.
package gf180mcu_fd_sc_mcu9t5v0__latrf_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    PULSE = 2'd2,
    HOLD  = 2'd3
  } wst_e;

  // Clock cycles per accepted write, accept edge to next possible accept edge.
  localparam int PHASE_CYCLES = 4;

endpackage

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__latrf_dec.sv
// Row address to one-hot decoder; vld flags addresses inside the populated rows.
module gf180mcu_fd_sc_mcu9t5v0__latrf_dec #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic [AW-1:0]    addr,
  output logic [DEPTH-1:0] onehot,
  output logic             vld
);

  always_comb begin
    onehot = '0;
    for (int i = 0; i < DEPTH; i++)
      if (addr == AW'(i)) onehot[i] = 1'b1;
  end

  // DEPTH need not be a power of two, so the top codes can be unpopulated.
  assign vld = ({{(32-AW){1'b0}}, addr} < 32'(DEPTH));

endmodule

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__latrf_wctl.sv
// Write controller: turns accepted requests into a SETUP/PULSE/HOLD sequence
// driving a registered one-hot latch enable and a held data bus.
module gf180mcu_fd_sc_mcu9t5v0__latrf_wctl
  import gf180mcu_fd_sc_mcu9t5v0__latrf_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     CLK,
  input  logic                     RN,
  input  logic                     WV,
  output logic                     WREADY,
  input  logic [$clog2(DEPTH)-1:0] WA,
  input  logic [WIDTH-1:0]         WDAT,
  output logic [DEPTH-1:0]         E,
  output logic [WIDTH-1:0]         D,
  output logic                     ERR,
  input  logic                     ERRCLR
);

  localparam int AW = $clog2(DEPTH);

  wst_e             state, state_nx;
  logic [DEPTH-1:0] row_oh, oh_q;
  logic [WIDTH-1:0] data_q;
  logic             row_vld;
  logic             accept;

  gf180mcu_fd_sc_mcu9t5v0__latrf_dec #(.DEPTH(DEPTH), .AW(AW)) u_dec (
    .addr   (WA),
    .onehot (row_oh),
    .vld    (row_vld)
  );

  // WREADY is only ever high in IDLE, so it doubles as the idle qualifier.
  assign accept = WV && WREADY;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept && row_vld) state_nx = SETUP;
      SETUP:   state_nx = PULSE;
      PULSE:   state_nx = HOLD;
      HOLD:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RN) begin
      state  <= IDLE;
      WREADY <= 1'b1;
      oh_q   <= '0;
      data_q <= '0;
      E      <= '0;
      D      <= '0;
      ERR    <= 1'b0;
    end else begin
      state  <= state_nx;
      WREADY <= (state_nx == IDLE);
      if (accept && row_vld) begin
        oh_q   <= row_oh;
        data_q <= WDAT;
      end
      if (state == SETUP) D <= data_q;
      // Row select is decoded before the flop so each E bit is a clean flop output.
      E <= (state == PULSE) ? oh_q : '0;
      if (accept && !row_vld) ERR <= 1'b1;
      else if (ERRCLR)        ERR <= 1'b0;
    end
  end

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__latrf_wctl.sv
// Bench: DEPTH=8 and DEPTH=6 controllers on shared stimulus, cycle model plus latch-array readback.
module tb_gf180mcu_fd_sc_mcu9t5v0__latrf_wctl;

  logic       CLK = 1'b0;
  logic       RN, WV, ERRCLR;
  logic [2:0] WA;
  logic [7:0] WDAT;
  logic       rdy0, rdy1, err0, err1;
  logic [7:0] e0, d0, d1;
  logic [5:0] e1;

  gf180mcu_fd_sc_mcu9t5v0__latrf_wctl #(.DEPTH(8), .WIDTH(8)) u_dut8 (
    .CLK(CLK), .RN(RN), .WV(WV), .WREADY(rdy0), .WA(WA), .WDAT(WDAT),
    .E(e0), .D(d0), .ERR(err0), .ERRCLR(ERRCLR));

  gf180mcu_fd_sc_mcu9t5v0__latrf_wctl #(.DEPTH(6), .WIDTH(8)) u_dut6 (
    .CLK(CLK), .RN(RN), .WV(WV), .WREADY(rdy1), .WA(WA), .WDAT(WDAT),
    .E(e1), .D(d1), .ERR(err1), .ERRCLR(ERRCLR));

  always #5 CLK = ~CLK;

  int   vecs = 0, miss = 0;
  bit   chk_en = 1'b0;
  int   depth [2] = '{8, 6};
  // Model: age counts edges since accept (0 = idle); D loads at age 2, E pulses at age 3.
  int         age   [2];
  logic [2:0] maddr [2];
  logic [7:0] mdata [2], mE [2], mD [2];
  bit         mrdy  [2], merr [2];
  logic [7:0] refm  [2][8];
  logic [7:0] lat   [2][8];
  int         nwr = 0;
  bit         acc;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 10 && !(rdy0 && rdy1); k++) tick();
    chk("idle_timeout", {30'd0, rdy0, rdy1}, 32'd3);
  endtask

  always @(posedge CLK) begin
    for (int i = 0; i < 2; i++) begin
      if (!RN) begin
        age[i] = 0; mE[i] = '0; mD[i] = '0; merr[i] = 1'b0; mrdy[i] = 1'b1;
      end else begin
        acc = WV && (age[i] == 0);
        if (ERRCLR) merr[i] = 1'b0;
        if (acc && int'(WA) >= depth[i]) merr[i] = 1'b1;
        if (age[i] != 0) age[i] = (age[i] == 3) ? 0 : age[i] + 1;
        if (acc && int'(WA) < depth[i]) begin
          age[i] = 1; maddr[i] = WA; mdata[i] = WDAT;
        end
        mE[i] = (age[i] == 3) ? 8'(1 << maddr[i]) : 8'h00;
        if (age[i] == 2) mD[i] = mdata[i];
        mrdy[i] = (age[i] == 0);
        if (age[i] == 3) begin
          refm[i][maddr[i]] = mdata[i];
          if (i == 0) nwr++;
        end
      end
    end
  end

  always @(negedge CLK) begin
    if (chk_en) begin
      for (int r = 0; r < 8; r++) if (e0[r]) lat[0][r] = d0;
      for (int r = 0; r < 6; r++) if (e1[r]) lat[1][r] = d1;
      chk("E8", {24'd0, e0}, {24'd0, mE[0]});
      chk("E6", {26'd0, e1}, {24'd0, mE[1]});
      chk("D8", {24'd0, d0}, {24'd0, mD[0]});
      chk("D6", {24'd0, d1}, {24'd0, mD[1]});
      chk("WREADY8", {31'd0, rdy0}, {31'd0, mrdy[0]});
      chk("WREADY6", {31'd0, rdy1}, {31'd0, mrdy[1]});
      chk("ERR8", {31'd0, err0}, {31'd0, merr[0]});
      chk("ERR6", {31'd0, err1}, {31'd0, merr[1]});
      chk("E_onehot0", {31'd0, ($onehot0(e0) && $onehot0(e1))}, 32'd1);
    end
  end

  initial begin
    for (int i = 0; i < 2; i++)
      for (int r = 0; r < 8; r++) begin
        refm[i][r] = '0; lat[i][r] = '0;
      end
    RN = 1'b0; WV = 1'b0; ERRCLR = 1'b0; WA = '0; WDAT = '0;
    tick(); tick();
    chk_en = 1'b1;
    chk("rst_wready", {31'd0, rdy0}, 32'd1);
    chk("rst_E", {24'd0, e0}, 32'd0);
    chk("rst_D", {24'd0, d0}, 32'd0);
    chk("rst_ERR", {31'd0, err1}, 32'd0);
    RN = 1'b1;
    tick();

    // Single write: row 3, 0xA5.
    WV = 1'b1; WA = 3'd3; WDAT = 8'hA5;
    tick();
    WV = 1'b0;
    tick();
    chk("t1_D", {24'd0, d0}, 32'hA5);
    chk("t1_E_setup", {24'd0, e0}, 32'd0);
    tick();
    chk("t1_E_pulse", {24'd0, e0}, 32'h08);
    tick();
    chk("t1_E_hold", {24'd0, e0}, 32'd0);
    tick();
    chk("t1_wready", {31'd0, rdy0}, 32'd1);

    // Back-to-back with WV held, inputs scrambled while busy.
    wait_idle();
    WV = 1'b1; WA = 3'd0; WDAT = 8'h11;
    tick();
    for (int k = 1; k <= 3; k++) begin
      WA = 3'($urandom); WDAT = 8'($urandom);
      tick();
      chk("t2_D_held", {24'd0, d0}, 32'h11);
      if (k == 2) chk("t2_E_row0", {24'd0, e0}, 32'h01);
    end
    WA = 3'd7; WDAT = 8'hEE;
    tick();
    chk("t2_err6_set", {31'd0, err1}, 32'd1);
    chk("t2_E6_none", {26'd0, e1}, 32'd0);
    WV = 1'b0;
    tick();
    chk("t2_D_new", {24'd0, d0}, 32'hEE);
    tick();
    chk("t2_E_row7", {24'd0, e0}, 32'h80);

    // ERRCLR together with another bad address: set wins; then clear alone.
    wait_idle();
    WV = 1'b1; WA = 3'd7; ERRCLR = 1'b1;
    tick();
    chk("t3_set_wins", {31'd0, err1}, 32'd1);
    WV = 1'b0;
    tick();
    chk("t3_clear", {31'd0, err1}, 32'd0);
    ERRCLR = 1'b0;

    // Reset on the edge that would start PULSE.
    wait_idle();
    WV = 1'b1; WA = 3'd2; WDAT = 8'h5A;
    tick();
    WV = 1'b0;
    tick();
    RN = 1'b0;
    tick();
    chk("t4_E", {24'd0, e0}, 32'd0);
    chk("t4_D", {24'd0, d0}, 32'd0);
    RN = 1'b1;
    tick();
    chk("t4_wready", {31'd0, rdy0}, 32'd1);
    chk("t4_E_after", {24'd0, e0}, 32'd0);

    // Random traffic into the latch arrays.
    begin
      int target;
      target = nwr + 1000;
      for (int c = 0; c < 20000 && nwr < target; c++) begin
        WV     = ($urandom_range(0, 3) != 0);
        WA     = 3'($urandom_range(0, 7));
        WDAT   = 8'($urandom);
        ERRCLR = ($urandom_range(0, 9) == 0);
        tick();
      end
      WV = 1'b0; ERRCLR = 1'b0;
      for (int k = 0; k < 5; k++) tick();
      chk("rand_writes_done", {31'd0, (nwr >= target)}, 32'd1);
    end

    for (int r = 0; r < 8; r++) chk("readback8", {24'd0, lat[0][r]}, {24'd0, refm[0][r]});
    for (int r = 0; r < 6; r++) chk("readback6", {24'd0, lat[1][r]}, {24'd0, refm[1][r]});

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
